alu_share_arbiter: RTL and testbench

//  Shares one combinational 8-bit ALU (a, b, operation -> out, carryOut) between two requesters.

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: default widths, FSM encoding and opcodes.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [OP_W_DEF-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W_DEF-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W_DEF-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W_DEF-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W_DEF-1:0] ALU_XOR = 3'b100;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_valid_o
);

    // Grant selection
    always_comb begin
        grant_o = 1'b0;
        case (valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two valid/ready requesters,
// registering operands before issue and holding the result until the owner takes it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_carry,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    output logic              busy,
    output logic              grant_id
);

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                grant_id_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   res_q;
    logic                carry_q;

    logic                grant_s;
    logic                any_valid_s;
    logic                accept_s;
    logic                rsp_take_s;
    logic [DATA_W-1:0]   a_mux_s, b_mux_s;
    logic [OP_W-1:0]     op_mux_s;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .any_valid_o  (any_valid_s)
    );

    assign accept_s   = (state_q == IDLE) && any_valid_s;
    assign rsp_take_s = (state_q == RESP) && (grant_id_q ? rsp1_ready : rsp0_ready);

    // Payload of the granted requester
    always_comb begin
        a_mux_s  = req0_a;
        b_mux_s  = req0_b;
        op_mux_s = req0_op;
        if (grant_s) begin
            a_mux_s  = req1_a;
            b_mux_s  = req1_b;
            op_mux_s = req1_op;
        end else begin
            a_mux_s  = req0_a;
            b_mux_s  = req0_b;
            op_mux_s = req0_op;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_valid_s ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = rsp_take_s ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; everything handshake-related is held low while reset is asserted
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    req0_ready = any_valid_s && !grant_s;
                    req1_ready = any_valid_s &&  grant_s;
                end
                EXEC: busy = 1'b1;
                RESP: begin
                    busy       = 1'b1;
                    rsp0_valid = !grant_id_q;
                    rsp1_valid =  grant_id_q;
                end
                default: busy = 1'b0;
            endcase
        end else begin
            busy = 1'b0;
        end
    end

    // Operand, ownership and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            if (accept_s) begin
                a_q        <= a_mux_s;
                b_q        <= b_mux_s;
                op_q       <= op_mux_s;
                grant_id_q <= grant_s;
            end
            if (state_q == EXEC) begin
                res_q   <= alu_out;
                carry_q <= alu_cout;
            end
            if (rsp_take_s) begin
                last_grant_q <= grant_id_q;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp0_data  = res_q;
    assign rsp0_carry = carry_q;
    assign rsp1_data  = res_q;
    assign rsp1_carry = carry_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a local ALU stands in for the team ALU and a queue-based
// scoreboard compares every response with an independent reference model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp0_carry;
    logic       rsp1_valid, rsp1_ready, rsp1_carry;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       alu_cout, busy, grant_id;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_cout(alu_cout),
        .busy(busy), .grant_id(grant_id)
    );

    // Stand-in for the external team ALU
    always_comb begin
        alu_out  = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            ALU_ADD: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] d;
        logic       c;
        d = 8'h00;
        c = 1'b0;
        case (op)
            3'd0: begin d = a + b;                 c = (int'(a) + int'(b)) > 255; end
            3'd1: begin d = a + (~b) + 8'd1;       c = (a < b);                   end
            3'd2: d = ~((~a) | (~b));
            3'd3: d = ~((~a) & (~b));
            3'd4: d = (a | b) & ~(a & b);
            default: d = 8'h00;
        endcase
        return {c, d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
    endtask

    // Presents a request, pushes its expected result once accepted; returns at the negedge in EXEC
    task automatic do_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          output int waited, output bit timeout);
        drive_req(id, a, b, op);
        waited  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                timeout = 1'b0;
                break;
            end
            tick();
            waited++;
        end
        if (!timeout) begin
            if (id) exp_q1.push_back(ref_alu(a, b, op));
            else    exp_q0.push_back(ref_alu(a, b, op));
        end
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Waits for requester id's response, completes the handshake and returns {carry,data}
    task automatic wait_rsp(input bit id, output logic [8:0] got, output bit timeout, output bit other_seen);
        timeout    = 1'b1;
        other_seen = 1'b0;
        got        = 9'h000;
        for (int i = 0; i < 30; i++) begin
            #1;
            if ((id ? rsp0_valid : rsp1_valid) === 1'b1) other_seen = 1'b1;
            if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        if (!timeout) begin
            got = id ? {rsp1_carry, rsp1_data} : {rsp0_carry, rsp0_data};
            if (id) rsp1_ready = 1'b1;
            else    rsp0_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_req(1'b0, 8'h55, 8'h66, ALU_ADD);
        tick(); tick();
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        req0_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({alu_a, alu_b, alu_op, grant_id, busy} !== 21'h0) begin
            bad++;
            $display("FAIL reset_regs: got a=%h b=%h op=%h gid=%b busy=%b expected all 0", alu_a, alu_b, alu_op, grant_id, busy);
        end
        tick();
    endtask

    task automatic test_req0();
        int w; bit to, other; logic [8:0] got, exp;
        do_req(1'b0, 8'h08, 8'h10, ALU_ADD, w, to);
        total++;
        if (to || w != 0) begin
            bad++;
            $display("FAIL req0_ready_same_cycle: got wait=%0d timeout=%0b expected wait=0", w, to);
        end
        #1;
        total++;
        if ({busy, rsp0_valid, grant_id, alu_a, alu_b} !== {1'b1, 1'b0, 1'b0, 8'h08, 8'h10}) begin
            bad++;
            $display("FAIL req0_exec: got busy=%b rsp0v=%b gid=%b a=%h b=%h expected 1 0 0 08 10", busy, rsp0_valid, grant_id, alu_a, alu_b);
        end
        tick();
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
            bad++;
            $display("FAIL req0_latency: got rsp0v=%b rsp1v=%b expected 1 0", rsp0_valid, rsp1_valid);
        end
        wait_rsp(1'b0, got, to, other);
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 9'h1FF;
        total++;
        if (to || got !== exp || got !== 9'h018) begin
            bad++;
            $display("FAIL req0_result: got %h expected %h (018) timeout=%0b", got, exp, to);
        end
    endtask

    task automatic test_req1();
        int w; bit to, other; logic [8:0] got, exp;
        do_req(1'b1, 8'hF0, 8'h20, ALU_ADD, w, to);
        wait_rsp(1'b1, got, to, other);
        exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h1FF;
        total++;
        if (to || got !== exp || got !== 9'h110) begin
            bad++;
            $display("FAIL req1_result: got %h expected %h (110) timeout=%0b", got, exp, to);
        end
        total++;
        if (other !== 1'b0) begin
            bad++;
            $display("FAIL req1_no_rsp0: got rsp0_valid seen=%b expected 0", other);
        end
    endtask

    task automatic test_contention();
        logic [7:0] a0, a1;
        bit g, found, rsp_seen;
        logic [8:0] got, exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a0 = 8'h11;
        a1 = 8'hC0;
        drive_req(1'b0, a0, 8'h22, ALU_ADD);
        drive_req(1'b1, a1, 8'h50, ALU_ADD);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (req0_ready || req1_ready) begin found = 1'b1; break; end
                tick();
            end
            total++;
            if (!found || (req0_ready && req1_ready)) begin
                bad++;
                $display("FAIL contention_ready: got r0=%b r1=%b found=%b expected exactly one", req0_ready, req1_ready, found);
                break;
            end
            g = req1_ready;
            total++;
            if (g !== ((k % 2) == 1)) begin
                bad++;
                $display("FAIL contention_order: got grant %0d at slot %0d expected %0d", g, k, k % 2);
            end
            if (g) exp_q1.push_back(ref_alu(a1, 8'h50, ALU_ADD));
            else   exp_q0.push_back(ref_alu(a0, 8'h22, ALU_ADD));
            tick();
            if (g) begin a1 = a1 + 8'h01; req1_a = a1; end
            else   begin a0 = a0 + 8'h01; req0_a = a0; end
            #1;
            total++;
            if (grant_id !== g || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL contention_busy: got gid=%b r0=%b r1=%b expected gid=%b r0=0 r1=0", grant_id, req0_ready, req1_ready, g);
            end
            rsp_seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if ((g ? rsp1_valid : rsp0_valid) === 1'b1) begin
                    got = g ? {rsp1_carry, rsp1_data} : {rsp0_carry, rsp0_data};
                    rsp_seen = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            if (g) exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h1FF;
            else   exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 9'h1FF;
            total++;
            if (!rsp_seen || got !== exp) begin
                bad++;
                $display("FAIL contention_result: got %h expected %h seen=%b", got, exp, rsp_seen);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int w; bit to, other, stable; logic [8:0] first, got, exp;
        do_req(1'b0, 8'h3C, 8'h0F, ALU_XOR, w, to);
        drive_req(1'b1, 8'h09, 8'h03, ALU_SUB);
        tick();
        #1;
        first  = {rsp0_carry, rsp0_data};
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (rsp0_valid !== 1'b1 || {rsp0_carry, rsp0_data} !== first || req1_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
            tick();
            #1;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL backpressure_hold: got rsp0v=%b data=%h r1=%b busy=%b expected 1 %h 0 1", rsp0_valid, {rsp0_carry, rsp0_data}, req1_ready, busy, first);
        end
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 9'h1FF;
        total++;
        if (first !== exp) begin
            bad++;
            $display("FAIL backpressure_result: got %h expected %h", first, exp);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        do_req(1'b1, 8'h09, 8'h03, ALU_SUB, w, to);
        total++;
        if (to || w != 0) begin
            bad++;
            $display("FAIL backpressure_next_grant: got wait=%0d timeout=%0b expected 0", w, to);
        end
        wait_rsp(1'b1, got, to, other);
        exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h1FF;
        total++;
        if (to || got !== exp) begin
            bad++;
            $display("FAIL backpressure_req1: got %h expected %h timeout=%0b", got, exp, to);
        end
    endtask

    task automatic test_reset_exec();
        int w; bit to, other, seen; logic [8:0] got, exp;
        do_req(1'b0, 8'h33, 8'h44, ALU_SUB, w, to);
        reset = 1'b1;
        #1;
        total++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_exec_during: got %b expected 00000", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        tick();
        reset = 1'b0;
        if (exp_q0.size() > 0) exp = exp_q0.pop_front();
        seen = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || alu_a !== 8'h00) begin
            bad++;
            $display("FAIL reset_exec_idle: got busy=%b alu_a=%h expected 0 00", busy, alu_a);
        end
        for (int i = 0; i < 3; i++) begin
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
            tick();
            #1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_exec_no_rsp: got rsp_valid seen=1 expected 0");
        end
        tick();
        do_req(1'b1, 8'h05, 8'h07, ALU_SUB, w, to);
        wait_rsp(1'b1, got, to, other);
        exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h000;
        total++;
        if (to || got !== exp || got !== 9'h1FE) begin
            bad++;
            $display("FAIL reset_exec_fresh: got %h expected %h (1fe) timeout=%0b", got, exp, to);
        end
    endtask

    task automatic test_op_sweep();
        int w; bit to, other, id; logic [8:0] got, exp;
        for (int op = 0; op < 5; op++) begin
            id = (op % 2) == 1;
            do_req(id, 8'h08, 8'h10, 3'(op), w, to);
            #1;
            total++;
            if (to || grant_id !== id) begin
                bad++;
                $display("FAIL sweep_grant_id: op=%0d got %b expected %b timeout=%0b", op, grant_id, id, to);
            end
            wait_rsp(id, got, to, other);
            if (id) exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h1FF;
            else    exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 9'h1FF;
            total++;
            if (to || got !== exp) begin
                bad++;
                $display("FAIL sweep_result: op=%0d got %h expected %h timeout=%0b", op, got, exp, to);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
        req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        test_reset();
        test_req0();
        test_req1();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_op_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
